// File: rtl/canvas_pkg.sv
// Shared types and helpers for the trace canvas: FSM encoding, address sizing
// and the default background colour.
package canvas_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      CLEAR = 1'b1
   } canvas_state_t;

   localparam logic [11:0] DEFAULT_BG = 12'hFFF;

   // Never returns 0 so a one-entry range still gets a 1-bit counter/address.
   function automatic int addr_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/canvas_tile_ram.sv
// Simple dual-port tile colour store: one write port, one read port.
// Read latency 1 cycle; a same-address read and write returns the old data.
module canvas_tile_ram #(
   parameter int AW = 12,
   parameter int DW = 12
) (
   input  logic          clk,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  logic [DW-1:0] wr_data,
   input  logic [AW-1:0] rd_addr,
   output logic [DW-1:0] rd_data
);

   logic [DW-1:0] mem [0:(1<<AW)-1];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
      rd_data <= mem[rd_addr];
   end

endmodule

// File: rtl/trace_canvas_gen.sv
// Tile canvas with a move-tick-driven cursor, pen tracing, hardware clear sweep
// and blinking cursor overlay; rgb follows x/y by two cycles.
module trace_canvas_gen
   import canvas_pkg::*;
#(
   parameter int          H_TILES     = 80,
   parameter int          V_TILES     = 30,
   parameter int          TILE_W_LOG2 = 3,
   parameter int          TILE_H_LOG2 = 4,
   parameter int          WRAP_MODE   = 1,
   parameter logic [11:0] BG_COLOR    = DEFAULT_BG,
   parameter int          BLINK_DIV   = 25_000_000
) (
   input  logic        clk_100MHz,
   input  logic        reset,
   input  logic        video_on,
   input  logic [9:0]  x,
   input  logic [9:0]  y,
   input  logic        move_left,
   input  logic        move_right,
   input  logic        move_up,
   input  logic        move_down,
   input  logic        trace,
   input  logic [11:0] pen_color,
   input  logic        clear_req,
   output logic        clear_busy,
   output logic [6:0]  cursor_x,
   output logic [4:0]  cursor_y,
   output logic [11:0] rgb
);

   localparam int NUM_TILES = H_TILES * V_TILES;
   localparam int AW        = addr_width(NUM_TILES);
   localparam int BW        = addr_width(BLINK_DIV);

   localparam logic [AW-1:0] LAST_ADDR = AW'(NUM_TILES - 1);
   localparam logic [6:0]    X_MAX     = 7'(H_TILES - 1);
   localparam logic [4:0]    Y_MAX     = 5'(V_TILES - 1);
   localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_DIV - 1);
   localparam logic          WRAP      = (WRAP_MODE != 0);

   canvas_state_t state, state_nxt;
   logic [AW-1:0] clr_addr, clr_addr_nxt;
   logic          wr_en;
   logic [AW-1:0] wr_addr;
   logic [11:0]   wr_data;
   logic [AW-1:0] cur_addr;

   logic [9:0]    row0, col0, row1, col1;
   logic          vid1;
   logic [AW-1:0] rd_addr;
   logic [11:0]   rd_data;
   logic          in_grid, on_cursor;

   logic [BW-1:0] blink_cnt;
   logic          blink_phase;

   // Cursor: opposing ticks cancel; edges wrap or hold depending on WRAP.
   always_ff @(posedge clk_100MHz or posedge reset) begin
      if (reset) begin
         cursor_x <= '0;
         cursor_y <= '0;
      end else begin
         if (move_right && !move_left) begin
            if (cursor_x == X_MAX) cursor_x <= WRAP ? 7'd0 : X_MAX;
            else                   cursor_x <= cursor_x + 7'd1;
         end else if (move_left && !move_right) begin
            if (cursor_x == 7'd0)  cursor_x <= WRAP ? X_MAX : 7'd0;
            else                   cursor_x <= cursor_x - 7'd1;
         end

         if (move_down && !move_up) begin
            if (cursor_y == Y_MAX) cursor_y <= WRAP ? 5'd0 : Y_MAX;
            else                   cursor_y <= cursor_y + 5'd1;
         end else if (move_up && !move_down) begin
            if (cursor_y == 5'd0)  cursor_y <= WRAP ? Y_MAX : 5'd0;
            else                   cursor_y <= cursor_y - 5'd1;
         end
      end
   end

   assign cur_addr = AW'(int'(cursor_y) * H_TILES + int'(cursor_x));

   always_ff @(posedge clk_100MHz or posedge reset) begin
      if (reset) begin
         state    <= CLEAR;
         clr_addr <= '0;
      end else begin
         state    <= state_nxt;
         clr_addr <= clr_addr_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      clr_addr_nxt = clr_addr;
      wr_en        = 1'b0;
      wr_addr      = cur_addr;
      wr_data      = pen_color;
      case (state)
         CLEAR: begin
            wr_en   = 1'b1;
            wr_addr = clr_addr;
            wr_data = BG_COLOR;
            if (clr_addr == LAST_ADDR) begin
               state_nxt    = IDLE;
               clr_addr_nxt = '0;
            end else begin
               clr_addr_nxt = clr_addr + AW'(1);
            end
         end
         default: begin
            if (clear_req) begin
               state_nxt    = CLEAR;
               clr_addr_nxt = '0;
            end else if (trace) begin
               wr_en = 1'b1;
            end
         end
      endcase
   end

   assign clear_busy = (state == CLEAR);

   canvas_tile_ram #(
      .AW (AW),
      .DW (12)
   ) u_ram (
      .clk     (clk_100MHz),
      .wr_en   (wr_en),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .rd_addr (rd_addr),
      .rd_data (rd_data)
   );

   // Off-grid rows/cols alias into the RAM; in_grid masks them downstream.
   assign row0    = y >> TILE_H_LOG2;
   assign col0    = x >> TILE_W_LOG2;
   assign rd_addr = AW'(int'(row0) * H_TILES + int'(col0));

   always_ff @(posedge clk_100MHz or posedge reset) begin
      if (reset) begin
         row1 <= '0;
         col1 <= '0;
         vid1 <= 1'b0;
      end else begin
         row1 <= row0;
         col1 <= col0;
         vid1 <= video_on;
      end
   end

   assign in_grid   = (row1 < 10'(V_TILES)) && (col1 < 10'(H_TILES));
   assign on_cursor = (row1 == {5'd0, cursor_y}) && (col1 == {3'd0, cursor_x});

   always_ff @(posedge clk_100MHz or posedge reset) begin
      if (reset)                       rgb <= '0;
      else if (!vid1)                  rgb <= '0;
      else if (!in_grid)               rgb <= BG_COLOR;
      else if (on_cursor && blink_phase) rgb <= ~rd_data;
      else                             rgb <= rd_data;
   end

   always_ff @(posedge clk_100MHz or posedge reset) begin
      if (reset) begin
         blink_cnt   <= '0;
         blink_phase <= 1'b0;
      end else if (blink_cnt == BLINK_MAX) begin
         blink_cnt   <= '0;
         blink_phase <= ~blink_phase;
      end else begin
         blink_cnt   <= blink_cnt + BW'(1);
      end
   end

endmodule

// File: tb/tb_trace_canvas_gen.sv
// Directed bench for trace_canvas_gen: a tile-level canvas model checked every
// cycle, plus literal expectations for the documented scenarios.
module tb_trace_canvas_gen;

   localparam int H  = 80;
   localparam int V  = 30;
   localparam int BD = 4;
   localparam logic [11:0] BG = 12'hFFF;

   logic        clk_100MHz = 1'b0;
   logic        reset      = 1'b1;
   logic        video_on   = 1'b0;
   logic [9:0]  x = '0, y = '0;
   logic        move_left = 1'b0, move_right = 1'b0, move_up = 1'b0, move_down = 1'b0;
   logic        trace = 1'b0;
   logic [11:0] pen_color = '0;
   logic        clear_req = 1'b0;

   logic        clear_busy, clear_busy_s;
   logic [6:0]  cursor_x, cursor_x_s;
   logic [4:0]  cursor_y, cursor_y_s;
   logic [11:0] rgb, rgb_s;

   int total = 0;
   int bad   = 0;

   always #5 clk_100MHz = ~clk_100MHz;

   trace_canvas_gen #(.WRAP_MODE(1), .BLINK_DIV(BD)) dut (
      .clk_100MHz (clk_100MHz), .reset (reset), .video_on (video_on),
      .x (x), .y (y),
      .move_left (move_left), .move_right (move_right),
      .move_up (move_up), .move_down (move_down),
      .trace (trace), .pen_color (pen_color), .clear_req (clear_req),
      .clear_busy (clear_busy), .cursor_x (cursor_x), .cursor_y (cursor_y),
      .rgb (rgb)
   );

   // Saturating twin: same stimulus, display disabled.
   trace_canvas_gen #(.WRAP_MODE(0), .BLINK_DIV(BD)) dut_sat (
      .clk_100MHz (clk_100MHz), .reset (reset), .video_on (1'b0),
      .x (x), .y (y),
      .move_left (move_left), .move_right (move_right),
      .move_up (move_up), .move_down (move_down),
      .trace (trace), .pen_color (pen_color), .clear_req (clear_req),
      .clear_busy (clear_busy_s), .cursor_x (cursor_x_s), .cursor_y (cursor_y_s),
      .rgb (rgb_s)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- tile-level model ----------------
   logic [11:0] canvas [V*H];
   bit          known  [V*H];
   int  busy_left = 0;
   int  mcx = 0, mcy = 0, scx = 0, scy = 0;
   int  cyc = 0;
   bit  s1_vid = 0, s1_known = 0;
   int  s1_row = 0, s1_col = 0;
   logic [11:0] s1_color = '0;
   logic [11:0] e_rgb = '0;
   bit  e_ok = 0;
   bit  started = 0;

   function automatic int step(input int c, input bit dec, input bit inc, input int n, input bit wrap);
      if (inc && !dec) return (c == n - 1) ? (wrap ? 0 : c) : c + 1;
      if (dec && !inc) return (c == 0) ? (wrap ? n - 1 : c) : c - 1;
      return c;
   endfunction

   task automatic model_step();
      int idx;
      if (reset) begin
         busy_left = H * V;
         mcx = 0; mcy = 0; scx = 0; scy = 0; cyc = 0;
         s1_vid = 0; e_rgb = '0; e_ok = 1;
         return;
      end
      // output stage uses the pixel sampled one cycle earlier
      if (!s1_vid) begin
         e_rgb = '0; e_ok = 1;
      end else if (s1_row >= V || s1_col >= H) begin
         e_rgb = BG; e_ok = 1;
      end else begin
         e_rgb = (s1_row == mcy && s1_col == mcx && ((cyc / BD) % 2 == 1)) ? ~s1_color : s1_color;
         e_ok  = s1_known;
      end
      s1_vid = video_on;
      s1_row = int'(y) / 16;
      s1_col = int'(x) / 8;
      if (s1_row < V && s1_col < H) begin
         s1_color = canvas[s1_row * H + s1_col];
         s1_known = known[s1_row * H + s1_col];
      end
      if (busy_left > 0) begin
         idx = H * V - busy_left;
         canvas[idx] = BG; known[idx] = 1;
         busy_left--;
      end else if (clear_req) begin
         busy_left = H * V;
      end else if (trace) begin
         canvas[mcy * H + mcx] = pen_color; known[mcy * H + mcx] = 1;
      end
      mcx = step(mcx, move_left, move_right, H, 1);
      mcy = step(mcy, move_up,   move_down,  V, 1);
      scx = step(scx, move_left, move_right, H, 0);
      scy = step(scy, move_up,   move_down,  V, 0);
      cyc++;
   endtask

   initial forever begin
      @(posedge clk_100MHz);
      model_step();
      started = 1;
   end

   always @(negedge clk_100MHz) begin
      if (started) begin
         check("busy",    clear_busy,   busy_left > 0);
         check("busy_s",  clear_busy_s, busy_left > 0);
         check("cx",      cursor_x,     mcx);
         check("cy",      cursor_y,     mcy);
         check("cx_s",    cursor_x_s,   scx);
         check("cy_s",    cursor_y_s,   scy);
         check("rgb_s",   rgb_s,        0);
         if (e_ok) check("rgb", rgb, e_rgb);
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick(input bit l, input bit r, input bit u, input bit d);
      @(negedge clk_100MHz); #1;
      move_left = l; move_right = r; move_up = u; move_down = d;
      @(negedge clk_100MHz); #1;
      move_left = 0; move_right = 0; move_up = 0; move_down = 0;
   endtask

   task automatic read_tile(input int row, input int col, output logic [11:0] v);
      @(negedge clk_100MHz); #1;
      x = 10'(col * 8); y = 10'(row * 16); video_on = 1;
      @(negedge clk_100MHz);
      @(negedge clk_100MHz);
      v = rgb;
   endtask

   task automatic scan_bg(input string name);
      int nbad = 0;
      logic [11:0] v;
      for (int r = 0; r < V; r++)
         for (int c = 0; c < H; c++) begin
            read_tile(r, c, v);
            if (!(r == mcy && c == mcx) && v !== BG) nbad++;
         end
      check(name, nbad, 0);
   endtask

   task automatic wait_clear(input int pulse_at, input int trace_off_at, output int n);
      n = 0;
      while (clear_busy && n < 3000) begin
         @(negedge clk_100MHz); n++;
         #1;
         clear_req = (n == pulse_at);
         if (n == trace_off_at) trace = 0;
      end
      clear_req = 0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

   initial begin
      int n;
      int n_f0f, n_0f0, n_other;
      logic [11:0] v;

      repeat (3) @(negedge clk_100MHz);
      check("rst_cx", cursor_x, 0);
      check("rst_cy", cursor_y, 0);
      check("rst_rgb", rgb, 0);
      check("rst_busy", clear_busy, 1);

      // reset mid-sweep restarts it
      #1 reset = 0;
      repeat (50) @(negedge clk_100MHz);
      #1 reset = 1;
      repeat (2) @(negedge clk_100MHz);
      #1 reset = 0;
      wait_clear(-1, -1, n);
      check("sweep_len_reset", n, 2400);
      check("busy_after_sweep", clear_busy, 0);
      scan_bg("scan_after_reset");

      // pen trace with two right moves
      @(negedge clk_100MHz); #1 pen_color = 12'h00F; trace = 1;
      tick(0, 1, 0, 0);
      tick(0, 1, 0, 0);
      @(negedge clk_100MHz); #1 trace = 0;
      check("trace_cx", cursor_x, 2);
      tick(0, 0, 0, 1);
      read_tile(0, 0, v); check("tile00", v, 12'h00F);
      read_tile(0, 1, v); check("tile01", v, 12'h00F);
      read_tile(0, 2, v); check("tile02", v, 12'h00F);
      read_tile(0, 3, v); check("tile03", v, BG);

      // edge handling: wrap vs saturate
      repeat (3) tick(1, 0, 0, 0);
      check("wrap_left", cursor_x, 79);
      check("sat_left", cursor_x_s, 0);
      tick(0, 1, 0, 0);
      check("wrap_right0", cursor_x, 0);
      repeat (79) tick(0, 1, 0, 0);
      check("sat_at79", cursor_x_s, 79);
      tick(0, 1, 0, 0);
      check("wrap_right", cursor_x, 0);
      check("sat_right", cursor_x_s, 79);
      tick(0, 0, 1, 0);
      tick(0, 0, 1, 0);
      check("wrap_up", cursor_y, 29);
      check("sat_up", cursor_y_s, 0);

      // opposing ticks cancel; diagonal moves apply on both axes
      repeat (10) tick(0, 1, 0, 0);
      tick(1, 1, 0, 0);
      check("lr_cancel", cursor_x, 10);
      tick(0, 0, 0, 1);
      tick(0, 1, 0, 1);
      check("diag_x", cursor_x, 11);
      check("diag_y", cursor_y, 1);

      // clear while tracing, with a redundant request mid-sweep
      @(negedge clk_100MHz); #1 pen_color = 12'h0A0; trace = 1;
      repeat (3) @(negedge clk_100MHz);
      #1 clear_req = 1;
      @(negedge clk_100MHz); #1 clear_req = 0;
      wait_clear(100, 2390, n);
      trace = 0;
      check("sweep_len_clear", n, 2400);
      scan_bg("scan_after_clear");

      // blink on the cursor tile (11,1) holding 0F0
      @(negedge clk_100MHz); #1 pen_color = 12'h0F0; trace = 1;
      @(negedge clk_100MHz); #1 trace = 0;
      read_tile(20, 5, v); check("park_bg", v, BG);
      #1 x = 10'd88; y = 10'd16;
      @(negedge clk_100MHz);
      check("lat1", rgb, BG);
      @(negedge clk_100MHz);
      check("lat2", (rgb == 12'hF0F) || (rgb == 12'h0F0), 1);
      n_f0f = 0; n_0f0 = 0; n_other = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk_100MHz);
         if (rgb == 12'hF0F)      n_f0f++;
         else if (rgb == 12'h0F0) n_0f0++;
         else                     n_other++;
      end
      check("blink_on", n_f0f, 4);
      check("blink_off", n_0f0, 4);
      check("blink_other", n_other, 0);
      #1 video_on = 0;
      @(negedge clk_100MHz);
      @(negedge clk_100MHz);
      check("video_off", rgb, 0);

      // off-grid pixels show the background
      read_tile(0, 87, v); check("offgrid_col", v, BG);
      read_tile(30, 0, v); check("offgrid_row", v, BG);

      @(negedge clk_100MHz);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
